// File: rtl/pc_sequencer_if.sv
// Instruction/flag/redirect bundle into the PC sequencer and its fetch-side results.
// The core drives through the master modport; the sequencer receives through slave.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              instr_valid;
  logic              stall;
  logic              is_branch;
  logic              is_call;
  logic              is_ret;
  logic              imm_valid;
  logic [3:0]        cond;
  logic              flag_z;
  logic              flag_s;
  logic              flag_o;
  logic              flag_c;
  logic              busy;
  logic [ADDR_W-1:0] target;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr0;
  logic [ADDR_W-1:0] fetch_addr1;
  logic              taken;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output instr_valid, stall, is_branch, is_call, is_ret, imm_valid, cond,
           flag_z, flag_s, flag_o, flag_c, busy, target,
           redirect_valid, redirect_pc,
    input  pc, fetch_addr0, fetch_addr1, taken, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  instr_valid, stall, is_branch, is_call, is_ret, imm_valid, cond,
           flag_z, flag_s, flag_o, flag_c, busy, target,
           redirect_valid, redirect_pc,
    output pc, fetch_addr0, fetch_addr1, taken, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with condition evaluation and a circular return-address stack.
// All outputs come from registers (fetch_addr1 is a pure function of the PC register).
module pc_sequencer #(
  parameter int                   ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int                   RAS_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [ADDR_W-1:0] pc_q;
  logic              taken_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic              accepted;
  logic              cond_ok;
  logic              ras_is_empty;
  logic              ras_is_full;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] ras_top;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;

  logic [ADDR_W-1:0] pc_d;
  logic              taken_d;
  logic              push;
  logic              pop;
  logic              err_set;

  assign accepted     = bus.instr_valid & ~bus.stall;
  assign seq          = pc_q + ONE + ADDR_W'(bus.imm_valid);
  assign ras_is_empty = (cnt_q == '0);
  assign ras_is_full  = (cnt_q == CNT_FULL);
  assign ptr_inc      = ptr_q + PTR_ONE;
  assign ptr_dec      = ptr_q - PTR_ONE;
  assign ras_top      = ras_mem[ptr_q];

  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      4'b0000: cond_ok = 1'b1;
      4'b0001: cond_ok = bus.flag_z;
      4'b0010: cond_ok = ~bus.flag_z;
      4'b0011: cond_ok = bus.flag_s ~^ bus.flag_o;
      4'b0100: cond_ok = bus.flag_z | (bus.flag_s ^ bus.flag_o);
      4'b0101: cond_ok = ~bus.flag_z & (bus.flag_s ~^ bus.flag_o);
      4'b0110: cond_ok = bus.flag_s ^ bus.flag_o;
      4'b0111: cond_ok = bus.flag_o;
      4'b1000: cond_ok = bus.busy;
      4'b1001: cond_ok = bus.flag_s;
      4'b1010: cond_ok = ~bus.flag_s;
      4'b1011: cond_ok = ~bus.flag_c;
      4'b1100: cond_ok = bus.flag_z | bus.flag_c;
      4'b1101: cond_ok = ~(bus.flag_z | bus.flag_c);
      4'b1110: cond_ok = bus.flag_c;
      4'b1111: cond_ok = ~bus.flag_o;
      default: cond_ok = 1'b0;
    endcase
  end

  // Redirect beats everything; a return beats branch/call in the same instruction.
  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      taken_d = 1'b1;
    end else if (accepted) begin
      if (bus.is_ret) begin
        if (ras_is_empty) begin
          pc_d    = seq;
          taken_d = 1'b0;
          err_set = 1'b1;
        end else begin
          pc_d    = ras_top;
          taken_d = 1'b1;
          pop     = 1'b1;
        end
      end else if ((bus.is_branch | bus.is_call) & cond_ok) begin
        pc_d    = bus.target;
        taken_d = 1'b1;
        if (bus.is_call) begin
          push = 1'b1;
          if (ras_is_full) err_set = 1'b1;
        end
      end else begin
        pc_d    = seq;
        taken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      if (err_set) err_q <= 1'b1;
      if (push) begin
        ptr_q <= ptr_inc;
        if (!ras_is_full) cnt_q <= cnt_q + CNT_ONE;
      end else if (pop) begin
        ptr_q <= ptr_dec;
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // When full, the slot above the top is the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (push && !rst) ras_mem[ptr_inc] <= seq;
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_addr0 = pc_q;
  assign bus.fetch_addr1 = pc_q + ONE;
  assign bus.taken       = taken_q;
  assign bus.ras_empty   = ras_is_empty;
  assign bus.ras_full    = ras_is_full;
  assign bus.ras_err     = err_q;

endmodule
